// File: rtl/hdmi_delay_tune.sv
// Closed-loop calibrator for the HDMI PLL feedback delay tap: sweeps all 16 taps,
// scores each by settled lock plus link quality, and drives the centre of the widest passing window.
module hdmi_delay_tune #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned SAMPLE_CYCLES = 4096,
  parameter int unsigned PASS_MIN      = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        pll_locked,
  input  logic        sample_ok,
  output logic [3:0]  delay,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [3:0]  window_lo,
  output logic [3:0]  window_hi,
  output logic [15:0] pass_map
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned CW = $clog2(SAMPLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_NEXT,
    S_PICK
  } state_t;

  state_t r_state, w_next;

  logic          r_lock_s1, r_lock_s2;
  logic [SW-1:0] r_settle;
  logic [TW-1:0] r_tmo;
  logic [CW-1:0] r_samp, r_good;
  logic [3:0]    r_tap;

  logic [3:0]    r_idx, r_cur_start, r_best_lo;
  logic [4:0]    r_cur_len, r_best_len;

  logic          w_settled, w_timeout, w_samp_last, w_tap_pass;
  logic [CW-1:0] w_good_total;
  logic          w_bit, w_better;
  logic [3:0]    w_run_start, w_best_lo, w_best_hi, w_centre;
  logic [4:0]    w_run_len, w_best_len, w_centre_sum;

  always_comb begin
    w_settled    = r_lock_s2 && (r_settle == SW'(SETTLE_CYCLES - 1));
    w_timeout    = (r_tmo == TW'(LOCK_TIMEOUT - 1));
    w_samp_last  = (r_samp == CW'(SAMPLE_CYCLES - 1));
    w_good_total = r_good + CW'(sample_ok);
    w_tap_pass   = (w_good_total >= CW'(PASS_MIN));
  end

  // Run tracker for the pick scan; strict '>' keeps the lowest-starting run on ties.
  always_comb begin
    w_bit        = pass_map[r_idx];
    w_run_start  = (r_cur_len == 5'd0) ? r_idx : r_cur_start;
    w_run_len    = w_bit ? (r_cur_len + 5'd1) : 5'd0;
    w_better     = w_bit && (w_run_len > r_best_len);
    w_best_lo    = w_better ? w_run_start : r_best_lo;
    w_best_len   = w_better ? w_run_len : r_best_len;
    w_best_hi    = w_best_lo + 4'(w_best_len - 5'd1);
    w_centre_sum = {1'b0, w_best_lo} + {1'b0, w_best_hi};
    w_centre     = w_centre_sum[4:1];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: begin
        if (w_settled)      w_next = S_SAMPLE;
        else if (w_timeout) w_next = S_NEXT;
      end
      S_SAMPLE: if (!r_lock_s2 || w_samp_last) w_next = S_NEXT;
      S_NEXT:   w_next = (r_tap == 4'd15) ? S_PICK : S_SETTLE;
      S_PICK:   if (r_idx == 4'd15) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lock_s1   <= 1'b0;
      r_lock_s2   <= 1'b0;
      r_settle    <= '0;
      r_tmo       <= '0;
      r_samp      <= '0;
      r_good      <= '0;
      r_tap       <= '0;
      r_idx       <= '0;
      r_cur_start <= '0;
      r_cur_len   <= '0;
      r_best_lo   <= '0;
      r_best_len  <= '0;
      delay       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      window_lo   <= '0;
      window_hi   <= '0;
      pass_map    <= '0;
    end else begin
      r_lock_s1 <= pll_locked;
      r_lock_s2 <= r_lock_s1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            fail     <= 1'b0;
            pass_map <= '0;
            r_tap    <= '0;
            delay    <= '0;
            r_settle <= '0;
            r_tmo    <= '0;
            r_samp   <= '0;
            r_good   <= '0;
          end
        end
        S_SETTLE: begin
          r_tmo    <= r_tmo + TW'(1);
          r_settle <= r_lock_s2 ? (r_settle + SW'(1)) : '0;
          if (w_settled) begin
            r_settle <= '0;
            r_tmo    <= '0;
            r_samp   <= '0;
            r_good   <= '0;
          end else if (w_timeout) begin
            pass_map[r_tap] <= 1'b0;
          end
        end
        S_SAMPLE: begin
          r_samp <= r_samp + CW'(1);
          r_good <= w_good_total;
          if (!r_lock_s2)       pass_map[r_tap] <= 1'b0;
          else if (w_samp_last) pass_map[r_tap] <= w_tap_pass;
        end
        S_NEXT: begin
          r_settle <= '0;
          r_tmo    <= '0;
          r_samp   <= '0;
          r_good   <= '0;
          if (r_tap != 4'd15) begin
            r_tap <= r_tap + 4'd1;
            delay <= r_tap + 4'd1;
          end else begin
            r_idx       <= '0;
            r_cur_start <= '0;
            r_cur_len   <= '0;
            r_best_lo   <= '0;
            r_best_len  <= '0;
          end
        end
        S_PICK: begin
          r_idx       <= r_idx + 4'd1;
          r_cur_start <= w_run_start;
          r_cur_len   <= w_run_len;
          r_best_lo   <= w_best_lo;
          r_best_len  <= w_best_len;
          if (r_idx == 4'd15) begin
            busy <= 1'b0;
            if (w_best_len != 5'd0) begin
              window_lo <= w_best_lo;
              window_hi <= w_best_hi;
              delay     <= w_centre;
              done      <= 1'b1;
            end else begin
              window_lo <= '0;
              window_hi <= '0;
              delay     <= '0;
              fail      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_delay_tune.sv
// Bench for hdmi_delay_tune: a PLL/link environment keyed on the driven tap, and a
// window-picking reference model that predicts every sweep's results.
module tb_hdmi_delay_tune;

  localparam int unsigned BUDGET = 3000;

  logic        clk = 1'b0;
  logic        reset_n, start, pll_locked, sample_ok;
  logic [3:0]  delay, window_lo, window_hi;
  logic        busy, done, fail;
  logic [15:0] pass_map;

  always #5 clk = ~clk;

  hdmi_delay_tune #(
    .SETTLE_CYCLES(4),
    .LOCK_TIMEOUT (64),
    .SAMPLE_CYCLES(8),
    .PASS_MIN     (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .pll_locked(pll_locked),
    .sample_ok (sample_ok),
    .delay     (delay),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .window_lo (window_lo),
    .window_hi (window_hi),
    .pass_map  (pass_map)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Environment: which taps lock, which taps give a clean link, optional lock glitch on tap 5
  logic [15:0] lock_tbl = '1;
  logic [15:0] ok_tbl   = '1;
  bit          glitch_en = 1'b0;
  int          n5 = 0;
  logic [3:0]  prev_d = '0;

  // Expected results of the current sweep
  int          phase = 0;
  logic [15:0] e_map;
  logic [3:0]  e_lo, e_hi, e_dly;
  bit          e_done, e_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Longest run of ones by exhaustive interval search; first found wins ties.
  function automatic void pick(input logic [15:0] m, output bit found,
                               output logic [3:0] lo, output logic [3:0] hi, output logic [3:0] d);
    int best;
    bit all;
    best = 0; lo = '0; hi = '0; d = '0;
    for (int a = 0; a < 16; a++) begin
      for (int b = a; b < 16; b++) begin
        all = 1'b1;
        for (int k = a; k <= b; k++) if (!m[k]) all = 1'b0;
        if (all && (b - a + 1) > best) begin
          best = b - a + 1;
          lo = 4'(a);
          hi = 4'(b);
        end
      end
    end
    found = (best > 0);
    if (found) d = 4'((int'(lo) + int'(hi)) / 2);
  endfunction

  task automatic pin(input logic [15:0] m, input bit ef, input logic [3:0] elo,
                     input logic [3:0] ehi, input logic [3:0] ed);
    bit f;
    logic [3:0] lo, hi, d;
    pick(m, f, lo, hi, d);
    check($sformatf("model_%04h_found", m), 32'(f), 32'(ef));
    check($sformatf("model_%04h_lo", m), 32'(lo), 32'(elo));
    check($sformatf("model_%04h_hi", m), 32'(hi), 32'(ehi));
    check($sformatf("model_%04h_delay", m), 32'(d), 32'(ed));
  endtask

  // PLL + link model driven from the tap the DUT presents
  initial begin
    pll_locked = 1'b0;
    sample_ok  = 1'b0;
    forever begin
      @(negedge clk);
      if (delay !== prev_d) n5 = 0;
      else                  n5++;
      prev_d     = delay;
      pll_locked = lock_tbl[delay] && !(glitch_en && delay == 4'd5 && n5 == 6);
      sample_ok  = ok_tbl[delay];
    end
  end

  // Compare process: flags low during a sweep, full result set once idle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (phase == 1) begin
        if (busy) begin
          check("busy_done_low", 32'(done), 32'd0);
          check("busy_fail_low", 32'(fail), 32'd0);
        end else begin
          phase = 2;
        end
      end
      if (phase == 2) begin
        check("res_busy", 32'(busy), 32'd0);
        check("res_done", 32'(done), 32'(e_done));
        check("res_fail", 32'(fail), 32'(e_fail));
        check("res_pass_map", 32'(pass_map), 32'(e_map));
        check("res_window_lo", 32'(window_lo), 32'(e_lo));
        check("res_window_hi", 32'(window_hi), 32'(e_hi));
        check("res_delay", 32'(delay), 32'(e_dly));
      end
    end
  end

  task automatic run_sweep(input string tag, input logic [15:0] lk, input logic [15:0] ok,
                           input bit gl, input bit noisy);
    bit fin;
    bit found;
    @(negedge clk);
    phase     = 0;
    lock_tbl  = lk;
    ok_tbl    = ok;
    glitch_en = gl;
    e_map = lk & ok;
    if (gl) e_map[5] = 1'b0;
    pick(e_map, found, e_lo, e_hi, e_dly);
    e_done = found;
    e_fail = !found;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    phase = 1;
    fin   = 1'b0;
    for (int c = 0; c < BUDGET && !fin; c++) begin
      @(negedge clk);
      if (!busy) begin
        start = 1'b0;
        fin   = 1'b1;
      end else begin
        start = noisy && ($urandom_range(0, 15) == 0);
      end
    end
    start = 1'b0;
    if (!fin) begin
      n_cmp++;
      n_err++;
      $display("FAIL sweep_timeout %s: busy still 1 after %0d cycles, want 0", tag, BUDGET);
      phase = 0;
    end else begin
      repeat (3) @(negedge clk);
    end
    glitch_en = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_fail"}, 32'(fail), 32'd0);
    check({tag, "_delay"}, 32'(delay), 32'd0);
    check({tag, "_window_lo"}, 32'(window_lo), 32'd0);
    check({tag, "_window_hi"}, 32'(window_hi), 32'd0);
    check({tag, "_pass_map"}, 32'(pass_map), 32'd0);
  endtask

  task automatic reset_mid_sweep();
    bit hit;
    @(negedge clk);
    phase    = 0;
    lock_tbl = '1;
    ok_tbl   = '1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit   = 1'b0;
    for (int c = 0; c < BUDGET && !hit; c++) begin
      @(negedge clk);
      if (delay == 4'd9) begin
        hit   = 1'b1;
        start = 1'b0;
      end else begin
        start = ($urandom_range(0, 7) == 0);
      end
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL reach_tap9: delay never reached 9 within %0d cycles, want 9", BUDGET);
    end
    // reset asserted together with a start pulse: reset must win
    reset_n = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    check_zero("rst_mid");
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst_idle");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;

    pin(16'hFFFF, 1'b1, 4'd0, 4'd15, 4'd7);
    pin(16'h03F8, 1'b1, 4'd3, 4'd9,  4'd6);
    pin(16'h3F0E, 1'b1, 4'd8, 4'd13, 4'd10);
    pin(16'h0E1C, 1'b1, 4'd2, 4'd4,  4'd3);
    pin(16'hFFDF, 1'b1, 4'd6, 4'd15, 4'd10);
    pin(16'h0000, 1'b0, 4'd0, 4'd0,  4'd0);

    run_sweep("all_pass",  16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    run_sweep("taps3_9",   16'hFFFF, 16'h03F8, 1'b0, 1'b0);
    run_sweep("two_runs",  16'hFFFF, 16'h3F0E, 1'b0, 1'b1);
    run_sweep("tie",       16'hFFFF, 16'h0E1C, 1'b0, 1'b0);
    run_sweep("no_lock",   16'h0000, 16'hFFFF, 1'b0, 1'b1);
    run_sweep("glitch5",   16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    reset_mid_sweep();

    for (int i = 0; i < 8; i++) begin
      logic [15:0] lk, ok;
      lk = 16'(~($urandom() & $urandom() & $urandom()));
      ok = 16'($urandom() | $urandom());
      run_sweep($sformatf("rand%0d", i), lk, ok, 1'b0, 1'b1);
    end

    phase = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
